// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: simple dual-port RAM with byte-lane writes, a zero-clearing
// init sequencer and a 0/1/2-cycle read pipeline with selectable
// same-address read-during-write behaviour.
module sdp_ram_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_DEPTH    = 16,
   parameter int BYTE_W       = 8,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = 0,
   localparam int NB = DATA_WIDTH / BYTE_W,
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  write,
   input  logic [NB-1:0]         write_be,
   input  logic [AW-1:0]         write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read_en,
   input  logic [AW-1:0]         read_addr,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid,
   output logic                  init_done
);

   // ---------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------
   if ((MEM_DEPTH < 32'sd2) || ((MEM_DEPTH & (MEM_DEPTH - 32'sd1)) != 32'sd0)) begin : g_err_depth
      $error("sdp_ram_pipe: MEM_DEPTH=%0d must be a power of 2 and >= 2", MEM_DEPTH);
   end
   if ((BYTE_W < 32'sd1) || ((DATA_WIDTH % BYTE_W) != 32'sd0)) begin : g_err_bytew
      $error("sdp_ram_pipe: DATA_WIDTH=%0d is not a multiple of BYTE_W=%0d", DATA_WIDTH, BYTE_W);
   end
   if ((READ_LATENCY < 32'sd0) || (READ_LATENCY > 32'sd2)) begin : g_err_lat
      $error("sdp_ram_pipe: READ_LATENCY=%0d must be 0, 1 or 2", READ_LATENCY);
   end

   localparam logic [AW-1:0] LAST_ADDR   = AW'(MEM_DEPTH - 32'sd1);
   localparam logic          WRITE_FIRST = (RDW_MODE != 32'sd0);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [AW-1:0]           init_cnt_r;
   logic [AW-1:0]           init_cnt_nxt_s;
   logic                    init_done_r;
   logic                    init_done_nxt_s;

   // Storage is deliberately not reset; only the init sequencer clears it.
   logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

   logic                    write_accept_s;
   logic                    read_accept_s;
   logic                    collide_s;
   logic [DATA_WIDTH-1:0]   rd_word_s;

   assign write_accept_s = write & init_done_r;
   assign read_accept_s  = read_en & init_done_r;
   assign collide_s      = write_accept_s & read_accept_s & (write_addr == read_addr);
   assign init_done      = init_done_r;

   // Init sequencer next-state: walk every address once, then park in READY.
   always_comb begin
      state_nxt_s    = state_r;
      init_cnt_nxt_s = init_cnt_r;
      case (state_r)
         ST_INIT: begin
            if (init_cnt_r == LAST_ADDR) begin
               state_nxt_s = ST_READY;
            end else begin
               init_cnt_nxt_s = init_cnt_r + AW'(1);
            end
         end
         ST_READY: begin
            state_nxt_s = ST_READY;
         end
         default: begin
            state_nxt_s    = ST_INIT;
            init_cnt_nxt_s = '0;
         end
      endcase
      init_done_nxt_s = (state_nxt_s == ST_READY);
   end

   // Init sequencer state, clear counter and registered init_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_INIT;
         init_cnt_r  <= '0;
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         init_cnt_r  <= init_cnt_nxt_s;
         init_done_r <= init_done_nxt_s;
      end
   end

   // Array update: zero-fill while initialising, byte-lane writes afterwards.
   always_ff @(posedge clk) begin
      if (state_r == ST_INIT) begin
         mem_r[init_cnt_r] <= '0;
      end else if (write_accept_s) begin
         for (int i = 0; i < NB; i++) begin
            if (write_be[i]) begin
               mem_r[write_addr][i*BYTE_W +: BYTE_W] <= write_data[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Word captured by a read: old data, or lane-merged write data on a
   // same-address collision when write-first forwarding is selected.
   always_comb begin
      rd_word_s = mem_r[read_addr];
      for (int i = 0; i < NB; i++) begin
         if (WRITE_FIRST && collide_s && write_be[i]) begin
            rd_word_s[i*BYTE_W +: BYTE_W] = write_data[i*BYTE_W +: BYTE_W];
         end else begin
            rd_word_s[i*BYTE_W +: BYTE_W] = mem_r[read_addr][i*BYTE_W +: BYTE_W];
         end
      end
   end

   if (READ_LATENCY == 32'sd0) begin : g_lat0
      // Combinational read always sees the array before this cycle's write.
      assign read_data  = mem_r[read_addr];
      assign read_valid = read_accept_s;
   end else begin : g_pipe
      logic [DATA_WIDTH-1:0]   data_pipe_r [READ_LATENCY];
      logic [READ_LATENCY-1:0] valid_pipe_r;

      // Read pipeline: data only advances with its valid, so the output holds.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_pipe_r <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
               data_pipe_r[s] <= '0;
            end
         end else begin
            valid_pipe_r[0] <= read_accept_s;
            if (read_accept_s) begin
               data_pipe_r[0] <= rd_word_s;
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
               valid_pipe_r[s] <= valid_pipe_r[s-1];
               if (valid_pipe_r[s-1]) begin
                  data_pipe_r[s] <= data_pipe_r[s-1];
               end
            end
         end
      end

      assign read_data  = data_pipe_r[READ_LATENCY-1];
      assign read_valid = valid_pipe_r[READ_LATENCY-1];
   end

endmodule

// File: doc/sdp_ram_pipe.md
SDP_RAM_PIPE -- requirements
Module: sdp_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 16, word count; power of 2, >= 2.
REQ-003 SHALL have parameter BYTE_W, default 8, byte-lane width; DATA_WIDTH is an integer multiple of BYTE_W; NB = DATA_WIDTH/BYTE_W.
REQ-004 SHALL have parameter READ_LATENCY, default 1, allowed values 0, 1 or 2 cycles.
REQ-005 SHALL have parameter RDW_MODE, default 0, same-address read-during-write policy: 0 = READ_FIRST, 1 = WRITE_FIRST.
REQ-006 SHALL report a violation of REQ-002 to REQ-004 with $error at elaboration.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 write  in  1  write request.
REQ-010 write_be  in  NB  per-lane write enable; bit i covers data bits [i*BYTE_W +: BYTE_W].
REQ-011 write_addr  in  clog2(MEM_DEPTH)  write word address.
REQ-012 write_data  in  DATA_WIDTH  write data.
REQ-013 read_en  in  1  read request.
REQ-014 read_addr  in  clog2(MEM_DEPTH)  read word address.
REQ-015 read_data  out  DATA_WIDTH  read data.
REQ-016 read_valid  out  1  read_data holds the result of an accepted read.
REQ-017 init_done  out  1  memory cleared; ports enabled.

Function
REQ-018 Storage SHALL be a register/distributed array; the array SHALL NOT be reset by rst_n, and is cleared by the init sequencer only.
REQ-019 The init sequencer SHALL have two states, INIT and READY; it enters INIT on reset.
REQ-020 In INIT, the block SHALL write all-zero to address init_cnt each cycle, with init_cnt counting 0 to MEM_DEPTH-1.
REQ-021 After writing address MEM_DEPTH-1, the sequencer SHALL move to READY; init_done SHALL be 1 from the next cycle, i.e. first high MEM_DEPTH cycles after reset release.
REQ-022 In READY, the sequencer SHALL stay in READY until the next reset.
REQ-023 While init_done=0, write and read_en SHALL be ignored: no array update, no read accepted, read_valid=0.
REQ-024 A write SHALL be accepted when write=1 and init_done=1; it updates only the lanes with write_be[i]=1 at that edge.
REQ-025 A write with write_be all-zero SHALL leave the array unchanged.
REQ-026 A read SHALL be accepted when read_en=1 and init_done=1; one read per cycle, fully pipelined, no stalls, no back-pressure.
REQ-027 With READ_LATENCY=0: read_data = array[read_addr] combinationally; read_valid = read_en & init_done.
REQ-028 With READ_LATENCY=L (1 or 2): the word is sampled in the accept cycle; read_valid=1 and read_data=that word exactly L cycles later.
REQ-029 Writes occurring after the accept cycle SHALL NOT alter an in-flight read.
REQ-030 For READ_LATENCY>=1, read_data SHALL hold its last value while read_valid=0.
REQ-031 Collision is defined as an accepted read and an accepted write to the same address in the same cycle.
REQ-032 On collision with READ_FIRST, the read SHALL return the pre-write word.
REQ-033 On collision with WRITE_FIRST and READ_LATENCY>=1, the read SHALL return the merged word: write_data on enabled lanes, old data on the others.
REQ-034 With READ_LATENCY=0, collisions SHALL always return the pre-write word; RDW_MODE is ignored.
REQ-035 Addresses SHALL be used modulo MEM_DEPTH (no out-of-range addresses exist at the port width); init_cnt SHALL not wrap beyond MEM_DEPTH-1.

Reset
REQ-036 On rst_n=0, the block SHALL asynchronously set init_done=0, read_valid=0, read_data=0, init_cnt=0 and state=INIT.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight reads (no read_valid after release for reads issued before reset).
REQ-038 After reset release, the sequencer SHALL restart the clear from address 0.
REQ-039 Reset asserted during INIT SHALL restart the sequence from address 0 with full MEM_DEPTH duration.

Verification (DATA_WIDTH=32, MEM_DEPTH=16, BYTE_W=8, READ_LATENCY=2 unless stated)
REQ-040 Release reset; issue read_en/write every cycle -> init_done rises exactly 16 cycles after release; nothing is written or read before it; a read of addr 5 afterwards returns 0x00000000.
REQ-041 Write 0xAABBCCDD to addr 3 with be=4'b1111, then be=4'b0101 with data 0x11223344; read addr 3 -> read_valid 2 cycles after read_en, data 0xAA22CC44.
REQ-042 Back-to-back reads of addrs 0..15 after writing addr*0x01010101 -> 16 consecutive read_valid cycles, in order, each returning its address pattern.
REQ-043 Same-cycle write 0xDEADBEEF (be=1111) and read to addr 7, which holds 0x12345678 -> RDW_MODE=0 returns 0x12345678; RDW_MODE=1 returns 0xDEADBEEF; with READ_LATENCY=0 it returns 0x12345678 in the same cycle.
REQ-044 Issue read of addr 2, then write addr 2 the next cycle -> the old value is returned (REQ-029).
REQ-045 Assert rst_n=0 one cycle after read_en -> read_data=0 and read_valid=0 immediately, no valid after release, init re-runs for 16 cycles, and previously written data reads back as 0.
